main_fsm: RTL and testbench

- Multicycle control state machine that sits directly upstream of the conditional-execution logic.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles from the instruction's Op/Funct fields.
- Emits the unconditioned write enables (RegW, MemW, NextPC, Branch) that the conditional logic gates with CondEx, plus the datapath mux selects.
- Handles one instruction at a time. Memory accesses may stall on a ready handshake.

---
 rtl/main_fsm_pkg.sv | 53 +++++
 rtl/main_fsm_outdec.sv | 74 +++++++
 rtl/main_fsm.sv | 91 +++++++++
 tb/tb_main_fsm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared state encoding, opcode values and datapath select constants for main_fsm.
package main_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SEL_W   = 2;

  // State encoding (FETCH must be zero)
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD    = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR    = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
  localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
  localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd9;
  localparam logic [STATE_W-1:0] S_UNKNOWN  = 4'd10;

  // Instruction classes
  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL = 2'b11;

  // ALUSrcB selects
  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  // Control word produced for each state
  typedef struct packed {
    logic             ir_write;
    logic             next_pc;
    logic             branch;
    logic             reg_w;
    logic             mem_w;
    logic             adr_src;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic             alu_op;
    logic [SEL_W-1:0] result_src;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decoder: maps a state code to its datapath control word.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  // Per-state control word; anything not named stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = 1'b0;
        ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = 1'b0;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b0;
      end
      S_MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b0;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      S_UNKNOWN: begin
        ctrl.illegal    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM: state register, next-state logic and reset gating.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               Branch,
  output logic               RegW,
  output logic               MemW,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic               ALUOp,
  output logic [SEL_W-1:0]   ResultSrc,
  output logic               Illegal
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] dec_state;
  logic               mem_ready;
  logic               unused_funct;
  ctrl_t              ctrl;

  // Funct bits between I and L carry no meaning for sequencing
  assign unused_funct = ^Funct[FUNCT_W-2:1];

  // With the handshake disabled every memory access completes in one cycle
  assign mem_ready = (USE_MEM_READY == 1'b0) || MemReady;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[FUNCT_W-1] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_UNKNOWN:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // During reset the selects present their FETCH values
  assign dec_state = reset ? S_FETCH : state_q;

  main_fsm_outdec u_outdec (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  // Enables are suppressed while reset is asserted
  assign IRWrite   = ctrl.ir_write & ~reset;
  assign NextPC    = ctrl.next_pc  & ~reset;
  assign Branch    = ctrl.branch   & ~reset;
  assign RegW      = ctrl.reg_w    & ~reset;
  assign MemW      = ctrl.mem_w    & ~reset;
  assign Illegal   = ctrl.illegal  & ~reset;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: phase-list reference model per instruction.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;

  logic       ir1, npc1, br1, rw1, mw1, adr1, sa1, aop1, ill1;
  logic [1:0] sb1, rs1;
  logic       ir2, npc2, br2, rw2, mw2, adr2, sa2, aop2, ill2;
  logic [1:0] sb2, rs2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(ir1), .NextPC(npc1), .Branch(br1), .RegW(rw1), .MemW(mw1),
    .AdrSrc(adr1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1),
    .ResultSrc(rs1), .Illegal(ill1)
  );

  main_fsm #(.USE_MEM_READY(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(1'b0),
    .IRWrite(ir2), .NextPC(npc2), .Branch(br2), .RegW(rw2), .MemW(mw2),
    .AdrSrc(adr2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2),
    .ResultSrc(rs2), .Illegal(ill2)
  );

  // Observed control word: {IRWrite,NextPC,Branch,RegW,MemW,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,Illegal}
  logic [12:0] obs1, obs2;
  assign obs1 = {ir1, npc1, br1, rw1, mw1, adr1, sa1, sb1, aop1, rs1, ill1};
  assign obs2 = {ir2, npc2, br2, rw2, mw2, adr2, sa2, sb2, aop2, rs2, ill2};

  function automatic logic [12:0] mk(input bit ir, npc, br, rw, mw, adr, sa,
                                     input bit [1:0] sb, input bit aop,
                                     input bit [1:0] rs, input bit il);
    return {ir, npc, br, rw, mw, adr, sa, sb, aop, rs, il};
  endfunction

  // Expected control word for each named phase, straight from the output table
  function automatic logic [12:0] exp_word(input string ph);
    case (ph)
      "FETCH":    return mk(1,1,0,0,0,0,1,2'b10,0,2'b10,0);
      "RESET":    return mk(0,0,0,0,0,0,1,2'b10,0,2'b10,0);
      "DECODE":   return mk(0,0,0,0,0,0,1,2'b10,0,2'b10,0);
      "MEMADR":   return mk(0,0,0,0,0,0,0,2'b01,0,2'b00,0);
      "MEMRD":    return mk(0,0,0,0,0,1,0,2'b00,0,2'b00,0);
      "MEMWR":    return mk(0,0,0,0,1,1,0,2'b00,0,2'b00,0);
      "MEMWB":    return mk(0,0,0,1,0,0,0,2'b00,0,2'b01,0);
      "EXECUTER": return mk(0,0,0,0,0,0,0,2'b00,1,2'b00,0);
      "EXECUTEI": return mk(0,0,0,0,0,0,0,2'b01,1,2'b00,0);
      "ALUWB":    return mk(0,0,0,1,0,0,0,2'b00,0,2'b00,0);
      "BRANCH":   return mk(0,0,1,0,0,0,0,2'b01,0,2'b10,0);
      "UNKNOWN":  return mk(0,0,0,0,0,0,0,2'b00,0,2'b00,1);
      default:    return 13'h1fff;
    endcase
  endfunction

  // Drives one instruction from FETCH back to FETCH, checking every cycle.
  // Precondition/postcondition: 1 time unit after a rising edge, DUT in FETCH.
  task automatic exec_instr(input bit use_nr, input logic [1:0] op,
                            input logic [5:0] fn, input int stalls, input string tag);
    string ph[$];
    logic [12:0] obs;
    int nst;
    nst = use_nr ? 0 : stalls;
    ph.push_back("FETCH");
    ph.push_back("DECODE");
    case (op)
      2'b00: begin
        ph.push_back(fn[5] ? "EXECUTEI" : "EXECUTER");
        ph.push_back("ALUWB");
      end
      2'b01: begin
        ph.push_back("MEMADR");
        for (int k = 0; k <= nst; k++) ph.push_back(fn[0] ? "MEMRD" : "MEMWR");
        if (fn[0]) ph.push_back("MEMWB");
      end
      2'b10: ph.push_back("BRANCH");
      default: ph.push_back("UNKNOWN");
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      obs = use_nr ? obs2 : obs1;
      n_checks++;
      if (obs !== exp_word(ph[i])) begin
        n_fail++;
        $display("FAIL %s cycle %0d (%s): got %b want %b", tag, i, ph[i], obs, exp_word(ph[i]));
      end
      // Op/Funct only meaningful when leaving DECODE or MEMADR; scramble elsewhere
      if (ph[i] == "DECODE" || ph[i] == "MEMADR") begin
        Op = op; Funct = fn;
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom);
      end
      if (ph[i] == "MEMRD" || ph[i] == "MEMWR")
        MemReady = use_nr ? 1'b0 : ((i + 1 < ph.size() && ph[i+1] == ph[i]) ? 1'b0 : 1'b1);
      else
        MemReady = 1'($urandom);
      @(posedge clk); #1;
    end
    obs = use_nr ? obs2 : obs1;
    n_checks++;
    if (obs !== exp_word("FETCH")) begin
      n_fail++;
      $display("FAIL %s end-in-fetch: got %b want %b", tag, obs, exp_word("FETCH"));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; MemReady = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs1 !== exp_word("RESET") || obs2 !== exp_word("RESET")) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b/%b want %b", c, obs1, obs2, exp_word("RESET"));
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ir1 !== 1'b1 || npc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: IRWrite=%b NextPC=%b want 1/1", ir1, npc1);
    end
  endtask

  task automatic resync();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_dp_reg();
    exec_instr(1'b0, 2'b00, 6'b000000, 0, "dp_reg_add");
  endtask

  task automatic test_dp_imm();
    exec_instr(1'b0, 2'b00, 6'b100000, 0, "dp_imm");
  endtask

  task automatic test_ldr_stall();
    exec_instr(1'b0, 2'b01, 6'b000001, 3, "ldr_stall3");
  endtask

  task automatic test_str();
    exec_instr(1'b0, 2'b01, 6'b000000, 0, "str_ready");
  endtask

  task automatic test_str_no_handshake();
    resync();
    exec_instr(1'b1, 2'b01, 6'b000000, 0, "str_no_handshake");
    resync();
  endtask

  task automatic test_branch_illegal();
    exec_instr(1'b0, 2'b10, 6'b000000, 0, "branch");
    exec_instr(1'b0, 2'b11, 6'b111111, 0, "illegal");
  endtask

  task automatic test_reset_in_stall();
    MemReady = 1'b0; Op = 2'b01; Funct = 6'b000000;
    @(posedge clk); #1;   // DECODE
    @(posedge clk); #1;   // MEMADR
    @(posedge clk); #1;   // MEMWR
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (mw1 !== 1'b1 || adr1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_memw[%0d]: MemW=%b AdrSrc=%b want 1/1", c, mw1, adr1);
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mw1 !== 1'b0 || rw1 !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_reset_gate: MemW=%b RegW=%b want 0/0", mw1, rw1);
    end
    @(posedge clk); #1;
    MemReady = 1'b1;
    n_checks++;
    if (obs1 !== exp_word("RESET")) begin
      n_fail++;
      $display("FAIL stall_reset_fetch: got %b want %b", obs1, exp_word("RESET"));
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs1 !== exp_word("FETCH")) begin
      n_fail++;
      $display("FAIL stall_reset_release: got %b want %b", obs1, exp_word("FETCH"));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      int st;
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      st = $urandom_range(0, 3);
      exec_instr(1'b0, op, fn, st, $sformatf("rand%0d_op%0d_fn%0h_st%0d", n, op, fn, st));
    end
  endtask

  initial begin
    test_reset();
    test_dp_reg();
    test_dp_imm();
    test_ldr_stall();
    test_str();
    test_branch_illegal();
    test_random();
    test_reset_in_stall();
    test_str_no_handshake();
    test_dp_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
